// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file write-back arbiter.
// Two write sources share one register-file write port. The pipeline source (A)
// has no backpressure and always wins. The multicycle source (B) is buffered in
// a DEPTH-entry FIFO and drains whenever A is idle. The selected write is
// presented on registered we/waddr/wdata one cycle later.
// Writes to register 0 are swallowed: an A write to r0 issues nothing, and a
// B write to r0 is handshaken but never buffered.
// Optional feature macro WB_FWD_EN adds a combinational probe that reports the
// youngest still-buffered B write to a given register.
module regfile_wb_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   input  logic [4:0]               a_waddr,
   input  logic [31:0]              a_wdata,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [4:0]               b_waddr,
   input  logic [31:0]              b_wdata,
   output logic                     we,
   output logic [4:0]               waddr,
   output logic [31:0]              wdata,
   output logic [$clog2(DEPTH):0]   b_count
`ifdef WB_FWD_EN
   ,
   input  logic [4:0]               fwd_raddr,
   output logic                     fwd_hit,
   output logic [31:0]              fwd_data
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [4:0]    fifo_addr_q [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          we_q, we_d;
   logic [4:0]    waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;

   logic          b_ready_c;
   logic          enq;
   logic          deq;

   // Handshake, arbitration and next-state for FIFO bookkeeping and write port.
   always_comb begin
      // b_ready depends only on the registered count; a same-cycle dequeue
      // does not open a slot until the next cycle.
      b_ready_c = (count_q != FULL_C);
      enq       = b_valid && b_ready_c && (b_waddr != 5'd0);
      deq       = !a_valid && (count_q != '0);

      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      if (a_valid) begin
         if (a_waddr != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = a_waddr;
            wdata_d = a_wdata;
         end
      end else if (deq) begin
         we_d    = 1'b1;
         waddr_d = fifo_addr_q[rd_ptr_q];
         wdata_d = fifo_data_q[rd_ptr_q];
      end

      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state and registered write port, synchronously cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   // FIFO storage; contents need no reset since count_q gates validity.
   always_ff @(posedge clk) begin
      if (!rst && enq) begin
         fifo_addr_q[wr_ptr_q] <= b_waddr;
         fifo_data_q[wr_ptr_q] <= b_wdata;
      end
   end

   assign b_ready = b_ready_c;
   assign we      = we_q;
   assign waddr   = waddr_q;
   assign wdata   = wdata_q;
   assign b_count = count_q;

`ifdef WB_FWD_EN
   logic [PW-1:0] fwd_idx;

   // Scan live entries oldest to youngest so the last match is the youngest.
   // The outgoing write register is deliberately not searched: the register
   // file bypasses that one itself.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (fwd_raddr != 5'd0) &&
             (fifo_addr_q[fwd_idx] == fwd_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data_q[fwd_idx];
         end
      end
      if (rst) begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
      end
   end
`endif

endmodule
